// File: rtl/div_calculator.sv
// Iterative radix-2 restoring divider for DIV/DIVU.
// Quotient on lo, remainder on hi; start/busy/done handshake.
module div_calculator #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_opr1,
   input  logic [WIDTH-1:0] i_opr2,
   input  logic             is_unsigned,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_div_by_zero,
   output logic [WIDTH-1:0] o_hi_result,
   output logic [WIDTH-1:0] o_lo_result
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dvsr_q, dvsr_d;
   logic [WIDTH-1:0] raw_q, raw_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic             dbz_q, dbz_d;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   rem_sh, trial;
   logic [WIDTH-1:0] quo_neg, rem_neg;

   always_comb begin
      a_neg   = !is_unsigned && i_opr1[WIDTH-1];
      b_neg   = !is_unsigned && i_opr2[WIDTH-1];
      a_mag   = a_neg ? -i_opr1 : i_opr1;
      b_mag   = b_neg ? -i_opr2 : i_opr2;
      // dividend bits stream out of quo_q as quotient bits stream in
      rem_sh  = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
      trial   = rem_sh - {1'b0, dvsr_q};
      quo_neg = -quo_q;
      rem_neg = -rem_q[WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvsr_d  = dvsr_q;
      raw_d   = raw_q;
      cnt_d   = cnt_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      zero_d  = zero_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               quo_d   = a_mag;
               dvsr_d  = b_mag;
               raw_d   = i_opr1;
               qneg_d  = a_neg ^ b_neg;
               rneg_d  = a_neg;
               zero_d  = (i_opr2 == '0);
               rem_d   = '0;
               cnt_d   = CNT_LAST;
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            rem_d = trial[WIDTH] ? rem_sh : trial;
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == '0) begin
               state_d = FIX;
            end
         end
         FIX: begin
            if (zero_q) begin
               lo_d  = '1;
               hi_d  = raw_q;
               dbz_d = 1'b1;
            end else begin
               lo_d  = qneg_q ? quo_neg : quo_q;
               hi_d  = rneg_q ? rem_neg : rem_q[WIDTH-1:0];
               dbz_d = 1'b0;
            end
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         quo_q   <= '0;
         dvsr_q  <= '0;
         raw_q   <= '0;
         cnt_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         zero_q  <= 1'b0;
         lo_q    <= '0;
         hi_q    <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvsr_q  <= dvsr_d;
         raw_q   <= raw_d;
         cnt_q   <= cnt_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         zero_q  <= zero_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         dbz_q   <= dbz_d;
      end
   end

   assign o_busy        = (state_q == CALC) || (state_q == FIX);
   assign o_done        = (state_q == DONE);
   assign o_div_by_zero = dbz_q;
   assign o_hi_result   = hi_q;
   assign o_lo_result   = lo_q;

endmodule

// File: doc/div_calculator.md
# div_calculator

Iterative 32-bit integer divider for the execute stage, servicing DIV/DIVU. It divides a dividend by a divisor in signed or unsigned mode and produces the quotient on the LO result and the remainder on the HI result, matching the HI/LO convention of the multiply unit. It uses a radix-2 restoring algorithm on operand magnitudes with a start/busy/done handshake, so the pipeline stalls on `o_busy` until `o_done`.

## Interface
- `WIDTH`, 32, operand and result width; only 32 is verified.

- `clk` input 1 — single clock; all state changes on the rising edge.
- `reset` input 1 — asynchronous, active-high; clears all state and outputs.
- `i_start` input 1 — request a division; sampled only when not busy.
- `i_opr1` input WIDTH — dividend; sampled with `i_start`.
- `i_opr2` input WIDTH — divisor; sampled with `i_start`.
- `is_unsigned` input 1 — 1 = DIVU, 0 = DIV (two's complement); sampled with `i_start`.
- `o_busy` output 1 — operation in progress; new starts are ignored.
- `o_done` output 1 — one-cycle pulse; results valid this cycle and held afterwards.
- `o_div_by_zero` output 1 — flag for the last completed operation; held with the results.
- `o_hi_result` output WIDTH — remainder.
- `o_lo_result` output WIDTH — quotient.

## Operation
- States: IDLE, CALC, FIX, DONE.
- **IDLE or DONE with `i_start` = 1:**
  - Latch the dividend and divisor magnitudes. In unsigned mode, or when the operand is non-negative, the magnitude is the raw operand. In signed mode with a negative operand, it is the two's complement, so 0x80000000 maps to the magnitude 2^31.
  - Latch `q_neg` = signed mode and (opr1[31] xor opr2[31]).
  - Latch `r_neg` = signed mode and opr1[31].
  - Latch the zero-divisor flag and the raw dividend.
  - Clear the 33-bit partial remainder and load the iteration counter with 31.
  - Next state is CALC.
- **IDLE or DONE with `i_start` = 0:** next state is IDLE. DONE always leaves after one cycle.
- **CALC:** each cycle performs one restoring step.
  - Shift {remainder, dividend} left by 1.
  - Compute trial = remainder − divisor at 33 bits.
  - If trial ≥ 0, remainder = trial and the quotient LSB = 1. Otherwise the remainder is restored and the LSB = 0.
  - The counter decrements. The step performed with counter = 0 is the last, and next state is FIX.
- **FIX:** register the results.
  - If the zero-divisor flag is set: lo = 0xFFFFFFFF, hi = raw latched dividend, `o_div_by_zero` = 1.
  - Otherwise: lo = `q_neg` ? −quotient : quotient, and hi = `r_neg` ? −remainder : remainder, both truncated to WIDTH. `o_div_by_zero` = 0.
  - Next state is DONE.
- Arithmetic truncates toward zero, and the remainder takes the sign of the dividend.
- Signed −2^31 / −1 gives lo = 0x80000000 and hi = 0 by natural wrap, with no flag.
- `o_busy` = 1 in CALC and FIX. `o_done` = 1 only in DONE.
- Results and `o_div_by_zero` hold their values until the next FIX updates them.
- `i_start` during CALC or FIX is ignored; it is neither queued nor aborting.

## Timing
- Reset values: state IDLE, `o_busy` 0, `o_done` 0, `o_div_by_zero` 0, `o_hi_result` 0, `o_lo_result` 0.
- Latency from start to done:
  - `i_start` is sampled at edge E0.
  - CALC occupies the cycles after edges E0 through E31 (32 steps).
  - FIX is the cycle after E32.
  - Results are registered at E33, and `o_done` is high for the cycle after E33.
  - Start to `o_done` is 34 cycles, identical for the divide-by-zero case.
- `o_busy` is high for exactly 33 cycles (the cycles after E0 through E32).
- Back-to-back operation: `i_start` asserted while `o_done` = 1 is accepted, so the next `o_busy` begins the following cycle. The previous results stay held until the new FIX.
- Reset asserted mid-operation forces the reset values immediately, without waiting for a clock. The operation is discarded and no `o_done` is produced.

## Test plan
- **Unsigned divide:** DIVU 100 / 7 → `o_done` exactly 34 cycles after start, lo = 14, hi = 2, `o_busy` high 33 cycles.
- **Signed divide:**
  - DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
  - DIV 7 / −2 → lo = 0xFFFFFFFD, hi = 1.
  - DIV −2^31 / −1 → lo = 0x80000000, hi = 0.
- **Unsigned extremes:**
  - DIVU 0xFFFFFFFF / 1 → lo = 0xFFFFFFFF, hi = 0.
  - DIVU 5 / 0xFFFFFFFF → lo = 0, hi = 5.
  - The same 0x80000000 / 0xFFFFFFFF as DIV → lo = 0x80000000, hi = 0.
- **Divide by zero:**
  - DIVU 1234 / 0 → lo = 0xFFFFFFFF, hi = 1234, `o_div_by_zero` = 1 held.
  - A following 9 / 3 → lo = 3, hi = 0, flag = 0.
- **Handshake:**
  - An `i_start` pulse with different operands at cycle 10 of an operation is ignored and the results match the first operation.
  - A start coincident with `o_done` launches a second operation whose `o_done` arrives 34 cycles later.
- **Reset:** assert `reset` at cycle 15 of an operation → all outputs 0 with no clock edge, state IDLE, no `o_done`. A fresh 100 / 7 then completes normally.
